// File: rtl/projection_sequencer.sv
// projection_sequencer: walks a programmable point table once per frame,
// drives each entry into the projector, waits out the projector latency,
// captures the projected coordinate and offers it to line_gen over a
// valid/ready handshake.
// Optional build macro PROJ_SEQ_CLIP_EN: off-screen points are skipped and
// pt_last_out marks the last point actually emitted (one-point lookahead).
// Scalar packing on the 48-bit buses: [15:0]=s0, [31:16]=s1, [47:32]=s2.
module projection_sequencer #(
  parameter int N_POINTS     = 16,
  parameter int PROJ_LATENCY = 2,
  parameter int H_ACTIVE     = 1280,
  parameter int V_ACTIVE     = 720
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start_in,
  input  logic                          cfg_we_in,
  input  logic [$clog2(N_POINTS)-1:0]   cfg_addr_in,
  input  logic signed [47:0]            cfg_scalars_in,
  input  logic [3:0]                    cfg_color_in,
  input  logic [$clog2(N_POINTS+1)-1:0] cfg_count_in,
  output logic signed [47:0]            proj_scalars_out,
  output logic [3:0]                    proj_color_out,
  input  logic signed [31:0]            x_proj_in,
  input  logic signed [31:0]            y_proj_in,
  input  logic [3:0]                    color_proj_in,
  output logic signed [31:0]            pt_x_out,
  output logic signed [31:0]            pt_y_out,
  output logic [3:0]                    pt_color_out,
  output logic                          pt_last_out,
  output logic                          pt_valid_out,
  input  logic                          pt_ready_in,
  output logic                          busy_out,
  output logic                          done_out
);

  localparam int AW = $clog2(N_POINTS);
  localparam int CW = $clog2(N_POINTS + 1);
  localparam int WW = (PROJ_LATENCY < 1) ? 1 : $clog2(PROJ_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      idx;
  logic [WW-1:0]      wait_cnt;
  logic [CW-1:0]      start_cnt;
  logic               at_last;

  logic signed [47:0] tbl_scalars [N_POINTS];
  logic [3:0]         tbl_color   [N_POINTS];

`ifdef PROJ_SEQ_CLIP_EN
  localparam logic signed [31:0] H_LIM = H_ACTIVE;
  localparam logic signed [31:0] V_LIM = V_ACTIVE;

  // Lookahead slot: holds the newest on-screen point until we know whether
  // another on-screen point follows it.
  logic               pend_vld;
  logic signed [31:0] pend_x;
  logic signed [31:0] pend_y;
  logic [3:0]         pend_color;

  function automatic logic in_screen(input logic signed [31:0] x,
                                     input logic signed [31:0] y);
    return (x >= 0) && (x < H_LIM) && (y >= 0) && (y < V_LIM);
  endfunction
`endif

  // A requested point count larger than the table is clamped to the table size.
  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c);
    if (int'(c) > N_POINTS) return CW'(N_POINTS);
    return c;
  endfunction

  assign start_cnt = sat_count(cfg_count_in);
  assign at_last   = (idx == cnt - CW'(1));

  // Point table: writable only while idle; out-of-range addresses are ignored.
  always_ff @(posedge clk_in) begin
    if (cfg_we_in && (state == S_IDLE) && (int'(cfg_addr_in) < N_POINTS)) begin
      tbl_scalars[cfg_addr_in] <= cfg_scalars_in;
      tbl_color[cfg_addr_in]   <= cfg_color_in;
    end
  end

  // Frame sequencer: issue, wait projector latency, capture, hand off.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= S_IDLE;
      cnt              <= '0;
      idx              <= '0;
      wait_cnt         <= '0;
      proj_scalars_out <= '0;
      proj_color_out   <= '0;
      pt_x_out         <= '0;
      pt_y_out         <= '0;
      pt_color_out     <= '0;
      pt_last_out      <= 1'b0;
      pt_valid_out     <= 1'b0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
`ifdef PROJ_SEQ_CLIP_EN
      pend_vld         <= 1'b0;
      pend_x           <= '0;
      pend_y           <= '0;
      pend_color       <= '0;
`endif
    end else begin
      done_out <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_in) begin
            cnt      <= start_cnt;
            idx      <= '0;
            busy_out <= 1'b1;
`ifdef PROJ_SEQ_CLIP_EN
            pend_vld <= 1'b0;
`endif
            if (start_cnt == '0) begin
              state    <= S_DONE;
              done_out <= 1'b1;
            end else begin
              state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          proj_scalars_out <= tbl_scalars[idx[AW-1:0]];
          proj_color_out   <= tbl_color[idx[AW-1:0]];
          wait_cnt         <= WW'(PROJ_LATENCY);
          state            <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WW'(1);
          end else begin
`ifdef PROJ_SEQ_CLIP_EN
            if (in_screen(x_proj_in, y_proj_in)) begin
              pend_x     <= x_proj_in;
              pend_y     <= y_proj_in;
              pend_color <= color_proj_in;
              pend_vld   <= 1'b1;
              if (pend_vld) begin
                // A successor exists, so the held point is not the last one.
                pt_x_out     <= pend_x;
                pt_y_out     <= pend_y;
                pt_color_out <= pend_color;
                pt_last_out  <= 1'b0;
                pt_valid_out <= 1'b1;
                state        <= S_EMIT;
              end else if (at_last) begin
                pt_x_out     <= x_proj_in;
                pt_y_out     <= y_proj_in;
                pt_color_out <= color_proj_in;
                pt_last_out  <= 1'b1;
                pt_valid_out <= 1'b1;
                pend_vld     <= 1'b0;
                state        <= S_EMIT;
              end else begin
                idx   <= idx + CW'(1);
                state <= S_ISSUE;
              end
            end else if (!at_last) begin
              idx   <= idx + CW'(1);
              state <= S_ISSUE;
            end else if (pend_vld) begin
              // Final table entry was off-screen: the held point closes the frame.
              pt_x_out     <= pend_x;
              pt_y_out     <= pend_y;
              pt_color_out <= pend_color;
              pt_last_out  <= 1'b1;
              pt_valid_out <= 1'b1;
              pend_vld     <= 1'b0;
              state        <= S_EMIT;
            end else begin
              state    <= S_DONE;
              done_out <= 1'b1;
            end
`else
            pt_x_out     <= x_proj_in;
            pt_y_out     <= y_proj_in;
            pt_color_out <= color_proj_in;
            pt_last_out  <= at_last;
            pt_valid_out <= 1'b1;
            state        <= S_EMIT;
`endif
          end
        end

        S_EMIT: begin
          if (pt_ready_in) begin
`ifdef PROJ_SEQ_CLIP_EN
            if (pt_last_out) begin
              pt_valid_out <= 1'b0;
              state        <= S_DONE;
              done_out     <= 1'b1;
            end else if (at_last) begin
              // Table exhausted with a point still held: emit it as last.
              pt_x_out     <= pend_x;
              pt_y_out     <= pend_y;
              pt_color_out <= pend_color;
              pt_last_out  <= 1'b1;
              pend_vld     <= 1'b0;
            end else begin
              pt_valid_out <= 1'b0;
              idx          <= idx + CW'(1);
              state        <= S_ISSUE;
            end
`else
            pt_valid_out <= 1'b0;
            if (pt_last_out) begin
              state    <= S_DONE;
              done_out <= 1'b1;
            end else begin
              idx   <= idx + CW'(1);
              state <= S_ISSUE;
            end
`endif
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          busy_out <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
